// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// The state encoding is fixed so that waveforms and debug probes stay stable across builds.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational full subtractor: d = x - y - bin.
// This is the half subtractor extended with a borrow input.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in over WIDTH cycles, LSB first.
// A single fs_cell is used, and the borrow is carried between cycles in a register.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_sh_next;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             bit_d, bit_bout;
  logic             accept;

  fs_cell u_fs_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (brw),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // A start request arriving in the DONE cycle is accepted in the same way as one arriving in IDLE.
  assign accept = start && (state != ST_SHIFT);
  assign busy   = (state == ST_SHIFT);
  assign done   = (state == ST_DONE);

  always_comb begin
    d_sh_next = d_sh >> 1;
    d_sh_next[WIDTH-1] = bit_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:  state_next = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_next = (cnt == CNT_LAST) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The visible result is written only on the final shift, so partial sums never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      d_sh       <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= borrow_in;
      cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= d_sh_next;
      brw  <= bit_bout;
      cnt  <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        difference <= d_sh_next;
        borrow_out <= bit_bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor, covering an 8-bit instance and a 1-bit instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       borrow_in = 1'b0;
  logic       busy, done, borrow_out;
  logic [7:0] difference;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       borrow_in1 = 1'b0;
  logic       busy1, done1, borrow_out1;
  logic [0:0] difference1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .difference(difference), .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .borrow_in(borrow_in1),
    .busy(busy1), .done(done1), .difference(difference1), .borrow_out(borrow_out1)
  );

  // Drives a one-cycle start pulse, then counts the edges until done is seen (the wait is bounded).
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi, output int n);
    @(negedge clk);
    a = av; b = bv; borrow_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, difference, borrow_out} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b, want all 0",
               busy, done, difference, borrow_out);
    end
    checks++;
    if ({busy1, done1, difference1, borrow_out1} !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_w1: got %b%b%b%b, want 0000", busy1, done1, difference1, borrow_out1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    run_op(8'h5A, 8'h3C, 1'b0, n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d edges, want 8", n);
    end
    checks++;
    if (difference !== 8'h1E || borrow_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: got %h/%b, want 1e/0", difference, borrow_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_single_cycle: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_borrow();
    int n;
    run_op(8'h00, 8'h01, 1'b0, n);
    checks++;
    if (n !== 8 || difference !== 8'hFF || borrow_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underflow: got n=%0d %h/%b, want 8 ff/1", n, difference, borrow_out);
    end
    run_op(8'h10, 8'h0F, 1'b1, n);
    checks++;
    if (n !== 8 || difference !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL borrow_in_zero: got n=%0d %h/%b, want 8 00/0", n, difference, borrow_out);
    end
  endtask

  task automatic test_hold();
    int bad = 0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; borrow_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b, want 1", busy);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (difference !== 8'h00 || done !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL hold_during_busy: got %0d bad cycles (last diff=%h), want 0 (diff 00)", bad, difference);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || difference !== 8'hFF || borrow_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL all_ones: got done=%b %h/%b, want 1 ff/1", done, difference, borrow_out);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    @(negedge clk);
    a = 8'h80; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    checks++;
    if (n !== 8 || difference !== 8'h7F || borrow_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_start: got n=%0d %h/%b, want 8 7f/0", n, difference, borrow_out);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got done=%b busy=%b, want 0/1", done, busy);
    end
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    checks++;
    if (n !== 8 || difference !== 8'h22 || borrow_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_result: got n=%0d %h/%b, want 8 22/0", n, difference, borrow_out);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses = 0;
    @(negedge clk);
    a = 8'hC3; b = 8'h12; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, difference, borrow_out} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b diff=%h bout=%b, want all 0",
               busy, done, difference, borrow_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || difference !== 8'h00) begin
      errors++;
      $display("[TB] FAIL no_done_after_reset: got %0d pulses diff=%h, want 0 00", pulses, difference);
    end
    run_op(8'h0F, 8'h03, 1'b1, n);
    checks++;
    if (n !== 8 || difference !== 8'h0B || borrow_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fresh_after_reset: got n=%0d %h/%b, want 8 0b/0", n, difference, borrow_out);
    end
  endtask

  task automatic test_width1();
    logic [1:0] expv [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = 1'(i >> 1); b1 = 1'(i); borrow_in1 = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || {difference1, borrow_out1} !== expv[i]) begin
        errors++;
        $display("[TB] FAIL width1_ab%0d: got done=%b d/bout=%b%b, want 1 %b",
                 i, done1, difference1, borrow_out1, expv[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
